// File: rtl/eeg_loader_pkg.sv
// Shared types and constants for the EEG sample loader.
// The sample conversion helper is used at FIFO push time.
package eeg_loader_pkg;

    localparam int unsigned ADC_BITWIDTH         = 16;
    localparam int unsigned Q_STO_INT_RES_DOUBLE = 20;
    localparam int unsigned INT_RES_DOUBLE_W     = 30;
    localparam int unsigned INT_RES_ADDR_W       = 16;
    localparam int unsigned SAMPLE_CNT_W         = 12;
    localparam int unsigned NUM_PATCHES          = 60;
    localparam int unsigned PATCH_LEN            = 64;
    localparam int unsigned EEG_INPUT_MEM        = 0;

    localparam int unsigned EEG_TO_FX_SHIFT = Q_STO_INT_RES_DOUBLE - (ADC_BITWIDTH - 1);
    localparam int unsigned ADC_MIDSCALE    = 2 ** (ADC_BITWIDTH - 1);

    typedef logic [ADC_BITWIDTH-1:0]     AdcData_t;
    typedef logic [INT_RES_ADDR_W-1:0]   IntResAddr_t;
    typedef logic [INT_RES_DOUBLE_W-1:0] IntResDouble_t;
    typedef logic [SAMPLE_CNT_W-1:0]     SampleCnt_t;

    typedef enum logic {
        SINGLE_WIDTH,
        DOUBLE_WIDTH
    } DataWidth_t;

    typedef enum logic [2:0] {
        INT_RES_SW_FX_1_X,
        INT_RES_SW_FX_2_X,
        INT_RES_SW_FX_5_X,
        INT_RES_SW_FX_6_X,
        INT_RES_DW_FX
    } FxFormatIntRes_t;

    typedef enum logic [1:0] {
        EEG_IDLE,
        EEG_LOAD,
        EEG_DRAIN
    } EegLoaderState_t;

    // Offset-binary ADC code to signed Q10.20; the range always fits, so no saturation.
    function automatic IntResDouble_t adc_to_fx(input AdcData_t d);
        logic signed [ADC_BITWIDTH:0]       s;
        logic signed [INT_RES_DOUBLE_W-1:0] ext;
        s   = $signed({1'b0, d}) - $signed((ADC_BITWIDTH + 1)'(ADC_MIDSCALE));
        ext = INT_RES_DOUBLE_W'(s);
        return IntResDouble_t'(ext <<< EEG_TO_FX_SHIFT);
    endfunction

endpackage

// File: rtl/eeg_loader_fifo.sv
// Generic synchronous FIFO with a registered head/valid pair, so consumers
// can drive registered outputs straight from it. Accepts push when full if popping.
module sample_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic             nonempty_next,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
    logic [AW:0]      count, count_n;
    logic             do_push, do_pop;

    assign empty         = (count == '0);
    assign full          = (count == (AW + 1)'(DEPTH));
    assign do_pop        = pop && !empty;
    assign do_push       = push && (!full || do_pop);
    assign count_n       = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    assign rd_ptr_n      = rd_ptr + AW'(do_pop);
    assign nonempty_next = (count_n != '0);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(do_push);
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            head_valid <= nonempty_next;
            // Pushed word becomes the head when nothing older remains after this pop.
            if (nonempty_next)
                head <= (do_push && count == (AW + 1)'(do_pop)) ? din : mem[rd_ptr_n];
        end
    end

endmodule

// File: rtl/eeg_loader.sv
// Loads one inference window of ADC samples into intermediate-result memory,
// converting each to double-width fixed point and buffering through a small FIFO.
module eeg_loader
    import eeg_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_SAMPLES = NUM_PATCHES * PATCH_LEN,
    parameter int unsigned BASE_ADDR   = EEG_INPUT_MEM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        adc_valid,
    input  logic [15:0] adc_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [29:0] wr_data,
    output logic        wr_width,
    output logic [2:0]  wr_format,
    input  logic        wr_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [11:0] sample_cnt
);

    EegLoaderState_t state;
    SampleCnt_t      push_cnt;
    SampleCnt_t      next_cnt;
    logic            fifo_full, fifo_empty, fifo_nonempty_next;
    logic            pop, push, in_window;

    assign wr_width  = DOUBLE_WIDTH;
    assign wr_format = INT_RES_DW_FX;

    assign pop       = wr_ack && !fifo_empty;
    assign in_window = (state == EEG_LOAD) && adc_valid &&
                       (push_cnt < SampleCnt_t'(NUM_SAMPLES));
    assign push      = in_window && (!fifo_full || pop);
    assign next_cnt  = sample_cnt + SampleCnt_t'(pop);

    sample_fifo #(
        .WIDTH(INT_RES_DOUBLE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .din          (adc_to_fx(adc_data)),
        .pop          (pop),
        .head         (wr_data),
        .head_valid   (wr_en),
        .nonempty_next(fifo_nonempty_next),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EEG_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
            push_cnt   <= '0;
            wr_addr    <= IntResAddr_t'(BASE_ADDR);
        end else begin
            done       <= 1'b0;
            sample_cnt <= next_cnt;
            if (push)              push_cnt <= push_cnt + 1'b1;
            if (in_window && !push) overflow <= 1'b1;
            // Address tracks the word that will be presented next; held while empty.
            if (fifo_nonempty_next)
                wr_addr <= IntResAddr_t'(BASE_ADDR) + IntResAddr_t'(next_cnt);

            case (state)
                EEG_IDLE: begin
                    if (start) begin
                        state      <= EEG_LOAD;
                        busy       <= 1'b1;
                        sample_cnt <= '0;
                        push_cnt   <= '0;
                        overflow   <= 1'b0;
                    end
                end
                EEG_LOAD: begin
                    if (push && push_cnt == SampleCnt_t'(NUM_SAMPLES - 1))
                        state <= EEG_DRAIN;
                end
                EEG_DRAIN: begin
                    if (pop && sample_cnt == SampleCnt_t'(NUM_SAMPLES - 1)) begin
                        state <= EEG_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= EEG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eeg_loader.sv
// Scoreboard bench for eeg_loader: a cycle-level occupancy model predicts
// accepted samples and status; a negedge monitor checks every memory write.
module tb_eeg_loader;
    import eeg_loader_pkg::*;

    localparam int NUM = 3840;

    logic        clk = 1'b0;
    logic        rst, start, adc_valid, wr_ack;
    logic [15:0] adc_data;
    logic        wr_en, wr_width, busy, done, overflow;
    logic [15:0] wr_addr;
    logic [29:0] wr_data;
    logic [2:0]  wr_format;
    logic [11:0] sample_cnt;

    always #5 clk = ~clk;

    eeg_loader #(.FIFO_DEPTH(4), .NUM_SAMPLES(NUM), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .adc_valid(adc_valid),
        .adc_data(adc_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_width(wr_width), .wr_format(wr_format),
        .wr_ack(wr_ack), .busy(busy), .done(done), .overflow(overflow),
        .sample_cnt(sample_cnt)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          addr;
        logic [29:0] data;
    } exp_t;
    exp_t sb[$];

    int m_occ, m_pushed, m_acc;
    bit m_busy, m_load, m_ovf, m_done;

    function automatic logic [29:0] ref_fx(input logic [15:0] d);
        int v;
        v = (int'(d) - 32768) * 32;
        return v[29:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_occ = 0; m_pushed = 0; m_acc = 0;
        m_busy = 0; m_load = 0; m_ovf = 0; m_done = 0;
    endtask

    // One clock cycle with the currently driven inputs, then status checks.
    task automatic tick();
        bit pop, elig, push, was_busy;
        was_busy = m_busy;
        pop  = (m_occ > 0) && wr_ack;
        elig = m_load && adc_valid && (m_pushed < NUM);
        push = elig && ((m_occ < 4) || pop);
        m_done = 0;
        if (elig && !push) m_ovf = 1;
        if (push) begin
            sb.push_back('{m_pushed, ref_fx(adc_data)});
            m_pushed++;
            if (m_pushed == NUM) m_load = 0;
        end
        if (pop) begin
            m_acc++;
            if (m_acc == NUM) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        m_occ += int'(push) - int'(pop);
        if (start && !was_busy) begin
            m_busy = 1; m_load = 1; m_pushed = 0; m_acc = 0; m_ovf = 0;
        end
        @(posedge clk);
        #1;
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("overflow", overflow, m_ovf);
        check("sample_cnt", sample_cnt, m_acc);
        check("wr_en", wr_en, m_occ > 0);
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_sample_cnt"}, sample_cnt, 0);
    endtask

    // Write monitor: checks stability while stalled and pops the scoreboard on accept.
    initial begin
        bit          hold;
        logic [15:0] p_addr;
        logic [29:0] p_data;
        exp_t        e;
        hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                check("stall_wr_en", wr_en, 1);
                check("stall_wr_addr", wr_addr, p_addr);
                check("stall_wr_data", wr_data, p_data);
            end
            if (wr_en) begin
                check("wr_width", wr_width, DOUBLE_WIDTH);
                check("wr_format", wr_format, INT_RES_DW_FX);
                if (wr_ack) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                    end
                    hold = 0;
                end else begin
                    hold   = 1;
                    p_addr = wr_addr;
                    p_data = wr_data;
                end
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0; wr_ack = 1'b0;
        model_clear();
        #2;
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Samples while idle must not produce writes.
        send(16'h1234, 3);

        // Window 1: conversion corners, start-while-busy, full window at 1/4 rate.
        wr_ack = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        send(16'h8000, 3);
        send(16'hFFFF, 3);
        send(16'h0000, 3);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 3; i < NUM; i++) send(16'($urandom), 3);
        n = 0;
        while ((busy || m_busy) && n < 100) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 100, 1);
        check("w1_sample_cnt", sample_cnt, NUM);
        check("w1_sb_empty", sb.size(), 0);
        send(16'h4321, 4);

        // Window 2: fill FIFO under stall, then push and pop in the same cycle.
        wr_ack = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) send(16'($urandom), 0);
        wr_ack = 1'b1;
        send(16'hA5A5, 0);
        check("pushpop_no_ovf", overflow, 0);
        n = 0;
        while (m_acc < 100 && n < 2000) begin
            wr_ack    = ($urandom_range(0, 3) != 0);
            adc_valid = $urandom_range(0, 1);
            adc_data  = 16'($urandom);
            tick();
            n++;
        end
        adc_valid = 1'b0;
        check("w2_progress_timeout", m_acc >= 100, 1);

        // Asynchronous reset in the middle of a window.
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Window 3: backpressure with six samples, then release.
        wr_ack = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) send(16'($urandom), 2);
        repeat (2) tick();
        check("bp_overflow", overflow, 1);
        wr_ack = 1'b1;
        repeat (8) tick();
        check("bp_sample_cnt", sample_cnt, 4);
        check("bp_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
